spi_master_mc: RTL

Parametrised multi-slave SPI master that succeeds the single-slave `spi_master` in the AXI4-to-SPI path. It accepts word commands on a valid/ready interface and drives one of `NUM_CS` chip selects. Each command carries its own SPI mode (CPOL/CPHA) and clock divider. Consecutive words can be chained under one held chip select. It sits in the SPI clock domain, between the bridge's command/response side and the SPI pads.

---
 rtl/spi_master_mc_if.sv | 30 +++
 rtl/spi_master_mc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_mc_if.sv
// Command/response bundle between the AXI4-to-SPI bridge and spi_master_mc.
// "master" is the bridge side issuing word commands and consuming responses;
// "slave" is the SPI engine side accepting commands and producing responses.
interface spi_master_mc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CS_IDX_W   = 2,
    parameter int DIV_WIDTH  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [CS_IDX_W-1:0]   cmd_cs;
    logic                  cmd_cpol;
    logic                  cmd_cpha;
    logic [DIV_WIDTH-1:0]  cmd_div;
    logic                  cmd_last;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output cmd_valid, cmd_cs, cmd_cpol, cmd_cpha, cmd_div, cmd_last, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_cs, cmd_cpol, cmd_cpha, cmd_div, cmd_last, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/spi_master_mc.sv
// Multi-slave SPI master: one word per command, per-command mode and divider,
// optional chaining of words under a held chip select.
// Optional feature macro: SPI_MC_LOOPBACK_EN -- when defined the receive
// sampler reads the internal MOSI register instead of the spi_miso pad.
module spi_master_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CS     = 4,
    parameter int CS_IDX_W   = 2,
    parameter int DIV_WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_master_mc_if.slave    bus,
    output logic              busy,
    output logic              spi_sclk,
    output logic [NUM_CS-1:0] spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
);
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, CHAIN, GAP} state_t;

    state_t                state;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  cnt;
    logic [EDGE_W-1:0]     edge_cnt;
    logic                  cpol_q;
    logic                  cpha_q;
    logic                  last_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic                  ready_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic                  cnt_done;
    logic                  accept;
    logic                  cs_ok;
    logic [NUM_CS-1:0]     cs_sel_n;
    logic                  lead_edge;
    logic                  sample_now;
    logic                  edge_tick;
    logic                  sample_bit;

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

`ifdef SPI_MC_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign sample_bit  = spi_mosi;
`else
    assign sample_bit  = spi_miso;
`endif

    assign cnt_done = (cnt == div_q);
    assign accept   = bus.cmd_valid && ready_q;
    assign cs_ok    = (int'(bus.cmd_cs) < NUM_CS);

    // The SETUP exit is SCLK edge 0 (always leading); inside SHIFT an even
    // edge count means the next edge is leading. Mode 0 samples on leading,
    // mode 1 on trailing, so sampling is simply leading XOR cpha.
    assign lead_edge  = (state == SETUP) ? 1'b1 : ~edge_cnt[0];
    assign sample_now = lead_edge ^ cpha_q;
    assign edge_tick  = cnt_done &&
                        ((state == SETUP) || ((state == SHIFT) && (edge_cnt != EDGE_LAST)));

    // Active-low one-hot decode of the requested chip select.
    always_comb begin
        for (int i = 0; i < NUM_CS; i++) begin
            cs_sel_n[i] = (int'(bus.cmd_cs) != i);
        end
    end

    // Transfer sequencer: command acceptance, SCLK generation, shifting and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            div_q       <= '0;
            cnt         <= '0;
            edge_cnt    <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            last_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            busy        <= 1'b0;
            spi_sclk    <= 1'b0;
            spi_cs_n    <= '1;
            spi_mosi    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;

            if (edge_tick) begin
                spi_sclk <= ~spi_sclk;
                edge_cnt <= edge_cnt + EDGE_W'(1);
                if (sample_now) begin
                    rx_q <= {rx_q[DATA_WIDTH-2:0], sample_bit};
                end else begin
                    spi_mosi <= tx_q[DATA_WIDTH-1];
                    tx_q     <= tx_q << 1;
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cs_ok) begin
                            spi_cs_n <= cs_sel_n;
                            spi_sclk <= bus.cmd_cpol;
                            cpol_q   <= bus.cmd_cpol;
                            cpha_q   <= bus.cmd_cpha;
                            div_q    <= bus.cmd_div;
                            last_q   <= bus.cmd_last;
                            if (!bus.cmd_cpha) begin
                                spi_mosi <= bus.cmd_wdata[DATA_WIDTH-1];
                                tx_q     <= bus.cmd_wdata << 1;
                            end else begin
                                tx_q     <= bus.cmd_wdata;
                            end
                            cnt      <= '0;
                            edge_cnt <= '0;
                            ready_q  <= 1'b0;
                            busy     <= 1'b1;
                            state    <= SETUP;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end

                CHAIN: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (accept) begin
                        div_q  <= bus.cmd_div;
                        last_q <= bus.cmd_last;
                        if (!cpha_q) begin
                            spi_mosi <= bus.cmd_wdata[DATA_WIDTH-1];
                            tx_q     <= bus.cmd_wdata << 1;
                        end else begin
                            tx_q     <= bus.cmd_wdata;
                        end
                        cnt      <= '0;
                        edge_cnt <= '0;
                        ready_q  <= 1'b0;
                        state    <= SETUP;
                    end
                end

                SETUP: begin
                    if (cnt_done) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end

                SHIFT: begin
                    if (cnt_done) begin
                        cnt <= '0;
                        if (edge_cnt == EDGE_LAST) begin
                            state <= HOLD;
                        end
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end

                HOLD: begin
                    if (cnt_done) begin
                        cnt         <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= rx_q;
                        if (last_q) begin
                            spi_cs_n <= '1;
                            state    <= GAP;
                        end else begin
                            state    <= CHAIN;
                        end
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end

                GAP: begin
                    if (cnt_done) begin
                        cnt     <= '0;
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // cpol is retained for the chained words so the idle level cannot change under CS.
    logic unused_cpol;
    assign unused_cpol = cpol_q;
endmodule
